// File: rtl/vx_csr_access_sched_if.sv
// Bus bundle for the CSR access scheduler: requester side, response side
// and the single-ported CSR storage read/write ports.
// master = requesters + CSR storage, slave = scheduler.
interface vx_csr_access_sched_if #(
  parameter int NUM_REQS  = 2,
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32,
  parameter int WID_BITS  = 2,
  parameter int UUID_BITS = 44
);
  localparam int IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  // requests
  logic [NUM_REQS-1:0]           req_valid;
  logic [NUM_REQS*2-1:0]         req_op;
  logic [NUM_REQS*ADDR_BITS-1:0] req_addr;
  logic [NUM_REQS*WID_BITS-1:0]  req_wid;
  logic [NUM_REQS*UUID_BITS-1:0] req_uuid;
  logic [NUM_REQS*DATA_BITS-1:0] req_data;
  logic [NUM_REQS-1:0]           req_ready;

  // response
  logic                 rsp_valid;
  logic [IDX_BITS-1:0]  rsp_idx;
  logic [DATA_BITS-1:0] rsp_data;
  logic [UUID_BITS-1:0] rsp_uuid;
  logic                 rsp_ready;

  // CSR storage ports
  logic                 read_enable;
  logic [ADDR_BITS-1:0] read_addr;
  logic [WID_BITS-1:0]  read_wid;
  logic [UUID_BITS-1:0] read_uuid;
  logic [DATA_BITS-1:0] read_data;
  logic                 write_enable;
  logic [ADDR_BITS-1:0] write_addr;
  logic [WID_BITS-1:0]  write_wid;
  logic [UUID_BITS-1:0] write_uuid;
  logic [DATA_BITS-1:0] write_data;

  modport master (
    output req_valid, req_op, req_addr, req_wid, req_uuid, req_data,
    input  req_ready,
    input  rsp_valid, rsp_idx, rsp_data, rsp_uuid,
    output rsp_ready,
    input  read_enable, read_addr, read_wid, read_uuid,
    output read_data,
    input  write_enable, write_addr, write_wid, write_uuid, write_data
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wid, req_uuid, req_data,
    output req_ready,
    output rsp_valid, rsp_idx, rsp_data, rsp_uuid,
    input  rsp_ready,
    output read_enable, read_addr, read_wid, read_uuid,
    input  read_data,
    output write_enable, write_addr, write_wid, write_uuid, write_data
  );
endinterface

// File: rtl/vx_csr_access_sched.sv
// Round-robin scheduler of CSR accesses onto single-ported CSR storage.
// Each access runs read -> optional write -> response, so CSRRW/RS/RC
// read-modify-write is atomic with respect to the other requesters.
module vx_csr_access_sched #(
  parameter int NUM_REQS  = 2,
  parameter int ADDR_BITS = 12,
  parameter int DATA_BITS = 32,
  parameter int WID_BITS  = 2,
  parameter int UUID_BITS = 44
) (
  input  logic clk,
  input  logic reset,
  input  logic fpu_pending,
  output logic busy,
  vx_csr_access_sched_if.slave bus
);
  localparam int IDX_BITS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_RSP   = 2'd3;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_RW   = 2'd1;
  localparam logic [1:0] OP_RS   = 2'd2;
  localparam logic [1:0] OP_RC   = 2'd3;

  logic [1:0]           state_reg, state_next;
  logic [IDX_BITS-1:0]  rr_ptr_reg;
  logic [1:0]           op_reg;
  logic [ADDR_BITS-1:0] addr_reg;
  logic [WID_BITS-1:0]  wid_reg;
  logic [UUID_BITS-1:0] uuid_reg;
  logic [DATA_BITS-1:0] data_reg;
  logic [IDX_BITS-1:0]  idx_reg;
  logic [DATA_BITS-1:0] old_reg;
  logic [DATA_BITS-1:0] new_reg;

  logic [NUM_REQS-1:0]  eligible;
  logic                 grant_valid;
  logic [IDX_BITS-1:0]  grant_idx;
  logic [IDX_BITS-1:0]  rr_ptr_next;
  int                   gsel;
  int                   scan;
  logic [DATA_BITS-1:0] new_value;
  logic                 write_needed;

  // FP CSRs (fflags/frm/fcsr) are held back while flag updates are in flight
  for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_elig
    logic [ADDR_BITS-1:0] addr_i;
    assign addr_i       = bus.req_addr[gi*ADDR_BITS +: ADDR_BITS];
    assign eligible[gi] = bus.req_valid[gi]
                        && !(fpu_pending && (addr_i != '0) && (addr_i <= ADDR_BITS'(3)));
    assign bus.req_ready[gi] = !reset && (state_reg == S_IDLE) && grant_valid
                             && (grant_idx == IDX_BITS'(gi));
  end

  // first eligible requester at or after rr_ptr, wrapping; the reverse scan
  // lets the closest candidate overwrite farther ones
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = '0;
    scan        = 0;
    for (int k = NUM_REQS - 1; k >= 0; k--) begin
      scan = int'(rr_ptr_reg) + k;
      if (scan >= NUM_REQS) scan = scan - NUM_REQS;
      if (eligible[scan]) begin
        grant_valid = 1'b1;
        grant_idx   = IDX_BITS'(scan);
      end
    end
  end

  assign gsel        = int'(grant_idx);
  assign rr_ptr_next = (grant_idx == IDX_BITS'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;

  // modified CSR value and whether the storage needs to be written at all
  always_comb begin
    case (op_reg)
      OP_RW:   new_value = data_reg;
      OP_RS:   new_value = bus.read_data | data_reg;
      OP_RC:   new_value = bus.read_data & ~data_reg;
      default: new_value = bus.read_data;
    endcase
    write_needed = (op_reg == OP_RW)
                || (((op_reg == OP_RS) || (op_reg == OP_RC)) && (data_reg != '0));
  end

  // sequencing: grant -> read -> (write) -> hold response until accepted
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (grant_valid) state_next = S_READ;
      S_READ:  state_next = write_needed ? S_WRITE : S_RSP;
      S_WRITE: state_next = S_RSP;
      default: if (bus.rsp_ready) state_next = S_IDLE;
    endcase
  end

  // state, arbitration pointer and captured access fields
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      rr_ptr_reg <= '0;
      op_reg     <= '0;
      addr_reg   <= '0;
      wid_reg    <= '0;
      uuid_reg   <= '0;
      data_reg   <= '0;
      idx_reg    <= '0;
      old_reg    <= '0;
      new_reg    <= '0;
    end else begin
      state_reg <= state_next;
      if ((state_reg == S_IDLE) && grant_valid) begin
        rr_ptr_reg <= rr_ptr_next;
        idx_reg    <= grant_idx;
        op_reg     <= bus.req_op[gsel*2 +: 2];
        addr_reg   <= bus.req_addr[gsel*ADDR_BITS +: ADDR_BITS];
        wid_reg    <= bus.req_wid[gsel*WID_BITS +: WID_BITS];
        uuid_reg   <= bus.req_uuid[gsel*UUID_BITS +: UUID_BITS];
        data_reg   <= bus.req_data[gsel*DATA_BITS +: DATA_BITS];
      end
      if (state_reg == S_READ) begin
        old_reg <= bus.read_data;
        new_reg <= new_value;
      end
    end
  end

  // strobes and valid are gated by reset so nothing leaks while it is held
  assign bus.read_enable  = !reset && (state_reg == S_READ);
  assign bus.write_enable = !reset && (state_reg == S_WRITE);
  assign bus.rsp_valid    = !reset && (state_reg == S_RSP);
  assign busy             = !reset && (state_reg != S_IDLE);

  assign bus.read_addr  = addr_reg;
  assign bus.read_wid   = wid_reg;
  assign bus.read_uuid  = uuid_reg;
  assign bus.write_addr = addr_reg;
  assign bus.write_wid  = wid_reg;
  assign bus.write_uuid = uuid_reg;
  assign bus.write_data = new_reg;
  assign bus.rsp_data   = old_reg;
  assign bus.rsp_idx    = idx_reg;
  assign bus.rsp_uuid   = uuid_reg;
endmodule

// File: tb/tb_vx_csr_access_sched.sv
// Directed bench for vx_csr_access_sched: reset, single read, RMW table,
// round-robin, response back-pressure, FP hold-off, reset mid-write.
module tb_vx_csr_access_sched;
  localparam int NUM_REQS  = 2;
  localparam int ADDR_BITS = 12;
  localparam int DATA_BITS = 32;
  localparam int WID_BITS  = 2;
  localparam int UUID_BITS = 44;

  localparam logic [1:0] OP_READ = 2'd0;
  localparam logic [1:0] OP_RW   = 2'd1;
  localparam logic [1:0] OP_RS   = 2'd2;
  localparam logic [1:0] OP_RC   = 2'd3;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic fpu_pending = 1'b0;
  logic busy;
  int total = 0;
  int bad = 0;

  vx_csr_access_sched_if #(
    .NUM_REQS(NUM_REQS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
    .WID_BITS(WID_BITS), .UUID_BITS(UUID_BITS)
  ) bus ();

  vx_csr_access_sched #(
    .NUM_REQS(NUM_REQS), .ADDR_BITS(ADDR_BITS), .DATA_BITS(DATA_BITS),
    .WID_BITS(WID_BITS), .UUID_BITS(UUID_BITS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fpu_pending(fpu_pending),
    .busy(busy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [UUID_BITS-1:0] uuid_of(input int i);
    return 44'h5A5_0000_0000 | UUID_BITS'(i);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_addr  = '0;
    bus.req_wid   = '0;
    bus.req_uuid  = '0;
    bus.req_data  = '0;
  endtask

  task automatic set_req(input int i, input logic [1:0] op,
                         input logic [ADDR_BITS-1:0] addr, input logic [DATA_BITS-1:0] data);
    bus.req_valid[i]                       = 1'b1;
    bus.req_op[i*2 +: 2]                   = op;
    bus.req_addr[i*ADDR_BITS +: ADDR_BITS] = addr;
    bus.req_wid[i*WID_BITS +: WID_BITS]    = WID_BITS'(i);
    bus.req_uuid[i*UUID_BITS +: UUID_BITS] = uuid_of(i);
    bus.req_data[i*DATA_BITS +: DATA_BITS] = data;
  endtask

  task automatic apply_reset();
    reset         = 1'b1;
    fpu_pending   = 1'b0;
    bus.rsp_ready = 1'b1;
    bus.read_data = '0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.rsp_ready = 1'b1;
    bus.read_data = 32'hFFFF_FFFF;
    clear_reqs();
    set_req(0, OP_RS, 12'h300, 32'h1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({bus.req_ready, bus.rsp_valid, busy, bus.read_enable, bus.write_enable} !== 6'b0) begin
      bad++;
      $display("FAIL reset_ctrl: got ready=%b rsp_valid=%b busy=%b re=%b we=%b, want all 0",
               bus.req_ready, bus.rsp_valid, busy, bus.read_enable, bus.write_enable);
    end
    total++;
    if (bus.rsp_data !== 32'h0 || bus.rsp_idx !== 1'b0 || bus.rsp_uuid !== 44'h0) begin
      bad++;
      $display("FAIL reset_rsp: got data=%h idx=%h uuid=%h, want 0", bus.rsp_data, bus.rsp_idx, bus.rsp_uuid);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_first_grant: got ready=%b busy=%b, want 01 0", bus.req_ready, busy);
    end
    $display("test_reset done");
  endtask

  task automatic test_read();
    apply_reset();
    bus.read_data = 32'h1234;
    set_req(0, OP_READ, 12'hC00, 32'h0);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01) begin
      bad++;
      $display("FAIL read_grant: got ready=%b want 01", bus.req_ready);
    end
    step();
    clear_reqs();
    @(negedge clk);
    total++;
    if (bus.read_enable !== 1'b1 || bus.write_enable !== 1'b0 || bus.read_addr !== 12'hC00 ||
        bus.read_wid !== 2'd0 || bus.read_uuid !== uuid_of(0) || busy !== 1'b1) begin
      bad++;
      $display("FAIL read_strobe: got re=%b we=%b addr=%h wid=%h uuid=%h busy=%b, want 1 0 c00 0 %h 1",
               bus.read_enable, bus.write_enable, bus.read_addr, bus.read_wid, bus.read_uuid, busy, uuid_of(0));
    end
    step();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h1234 || bus.rsp_idx !== 1'b0 ||
        bus.rsp_uuid !== uuid_of(0) || bus.write_enable !== 1'b0 || bus.read_enable !== 1'b0) begin
      bad++;
      $display("FAIL read_rsp: got v=%b data=%h idx=%h uuid=%h we=%b re=%b, want 1 1234 0 %h 0 0",
               bus.rsp_valid, bus.rsp_data, bus.rsp_idx, bus.rsp_uuid, bus.write_enable, bus.read_enable, uuid_of(0));
    end
    step();
    @(negedge clk);
    total++;
    if (bus.rsp_valid !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL read_idle: got rsp_valid=%b busy=%b, want 0 0", bus.rsp_valid, busy);
    end
    $display("test_read done");
  endtask

  task automatic test_rmw();
    logic [1:0]  t_op  [6] = '{OP_RS, OP_RS, OP_RC, OP_RW, OP_RC, OP_RW};
    int          t_req [6] = '{0, 0, 1, 1, 0, 1};
    logic [31:0] t_dat [6] = '{32'h8, 32'h0, 32'h1, 32'hAA, 32'h0, 32'h0};
    logic [31:0] t_old [6] = '{32'h3, 32'h3, 32'h3, 32'h55, 32'hF, 32'h7};
    logic        t_we  [6] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [31:0] t_wd  [6] = '{32'hB, 32'h0, 32'h2, 32'hAA, 32'h0, 32'h0};
    logic [NUM_REQS-1:0] onehot;
    logic [ADDR_BITS-1:0] addr;
    apply_reset();
    for (int v = 0; v < 6; v++) begin
      onehot = 2'b01 << t_req[v];
      addr = 12'h300 + ADDR_BITS'(v);
      set_req(t_req[v], t_op[v], addr, t_dat[v]);
      bus.read_data = t_old[v];
      @(negedge clk);
      total++;
      if (bus.req_ready !== onehot) begin
        bad++;
        $display("FAIL rmw%0d_grant: got ready=%b want %b", v, bus.req_ready, onehot);
      end
      step();
      clear_reqs();
      @(negedge clk);
      total++;
      if (bus.read_enable !== 1'b1 || bus.write_enable !== 1'b0 || bus.read_addr !== addr) begin
        bad++;
        $display("FAIL rmw%0d_read: got re=%b we=%b addr=%h, want 1 0 %h",
                 v, bus.read_enable, bus.write_enable, bus.read_addr, addr);
      end
      step();
      if (t_we[v]) begin
        @(negedge clk);
        total++;
        if (bus.write_enable !== 1'b1 || bus.write_data !== t_wd[v] || bus.write_addr !== addr ||
            bus.write_wid !== WID_BITS'(t_req[v]) || bus.read_enable !== 1'b0 || bus.rsp_valid !== 1'b0) begin
          bad++;
          $display("FAIL rmw%0d_write: got we=%b wd=%h addr=%h wid=%h re=%b rv=%b, want 1 %h %h %0d 0 0",
                   v, bus.write_enable, bus.write_data, bus.write_addr, bus.write_wid,
                   bus.read_enable, bus.rsp_valid, t_wd[v], addr, t_req[v]);
        end
        step();
      end
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== t_old[v] || bus.rsp_idx !== 1'(t_req[v]) ||
          bus.write_enable !== 1'b0) begin
        bad++;
        $display("FAIL rmw%0d_rsp: got v=%b data=%h idx=%h we=%b, want 1 %h %0d 0",
                 v, bus.rsp_valid, bus.rsp_data, bus.rsp_idx, bus.write_enable, t_old[v], t_req[v]);
      end
      step();
      $display("rmw vector %0d op=%0d data=%h old=%h done", v, t_op[v], t_dat[v], t_old[v]);
    end
  endtask

  task automatic test_back_to_back();
    logic [NUM_REQS-1:0] grants [4];
    int cyc [4];
    int n = 0;
    apply_reset();
    bus.read_data = 32'h77;
    set_req(0, OP_READ, 12'hC00, 32'h0);
    set_req(1, OP_READ, 12'hC01, 32'h0);
    for (int c = 0; c < 60 && n < 4; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        grants[n] = bus.req_ready;
        cyc[n] = c;
        n++;
      end
      step();
    end
    clear_reqs();
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL rr_timeout: got %0d grants, want 4", n);
    end else begin
      for (int g = 0; g < 4; g++) begin
        total++;
        if (grants[g] !== ((g % 2 == 0) ? 2'b01 : 2'b10)) begin
          bad++;
          $display("FAIL rr_order%0d: got ready=%b want %b", g, grants[g], (g % 2 == 0) ? 2'b01 : 2'b10);
        end
      end
      total++;
      if (cyc[1] - cyc[0] != 3 || cyc[3] - cyc[2] != 3) begin
        bad++;
        $display("FAIL rr_spacing: got gaps %0d %0d, want 3 3", cyc[1] - cyc[0], cyc[3] - cyc[2]);
      end
    end
    step();
    $display("test_back_to_back done, grants=%0d", n);
  endtask

  task automatic test_backpressure();
    apply_reset();
    bus.rsp_ready = 1'b0;
    bus.read_data = 32'h4321;
    set_req(0, OP_READ, 12'hC01, 32'h0);
    set_req(1, OP_READ, 12'hC02, 32'h0);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01) begin
      bad++;
      $display("FAIL bp_grant: got ready=%b want 01", bus.req_ready);
    end
    step();
    bus.req_valid[0] = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      bus.read_data = 32'hDEAD_0000 + 32'(k);
      @(negedge clk);
      total++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== 32'h4321 || bus.rsp_idx !== 1'b0 ||
          bus.req_ready !== 2'b00 || busy !== 1'b1) begin
        bad++;
        $display("FAIL bp_hold%0d: got v=%b data=%h idx=%h ready=%b busy=%b, want 1 4321 0 00 1",
                 k, bus.rsp_valid, bus.rsp_data, bus.rsp_idx, bus.req_ready, busy);
      end
      step();
    end
    bus.rsp_ready = 1'b1;
    step();
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b10 || bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_next: got ready=%b rsp_valid=%b, want 10 0", bus.req_ready, bus.rsp_valid);
    end
    step();
    clear_reqs();
    repeat (3) step();
    $display("test_backpressure done");
  endtask

  task automatic test_fpu_holdoff();
    apply_reset();
    fpu_pending = 1'b1;
    bus.read_data = 32'h9;
    set_req(0, OP_READ, 12'h003, 32'h0);
    set_req(1, OP_READ, 12'h300, 32'h0);
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b10) begin
      bad++;
      $display("FAIL fp_skip: got ready=%b want 10", bus.req_ready);
    end
    step();
    bus.req_valid[1] = 1'b0;
    step();
    step();
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b00 || busy !== 1'b0) begin
      bad++;
      $display("FAIL fp_blocked: got ready=%b busy=%b, want 00 0", bus.req_ready, busy);
    end
    step();
    bus.req_addr[11:0] = 12'h001;
    #1;
    total++;
    if (bus.req_ready !== 2'b00) begin
      bad++;
      $display("FAIL fp_addr001: got ready=%b want 00", bus.req_ready);
    end
    bus.req_addr[11:0] = 12'h004;
    #1;
    total++;
    if (bus.req_ready !== 2'b01) begin
      bad++;
      $display("FAIL fp_addr004: got ready=%b want 01", bus.req_ready);
    end
    bus.req_addr[11:0] = 12'h003;
    fpu_pending = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01) begin
      bad++;
      $display("FAIL fp_release: got ready=%b want 01", bus.req_ready);
    end
    step();
    clear_reqs();
    repeat (3) step();
    $display("test_fpu_holdoff done");
  endtask

  task automatic test_reset_mid_write();
    apply_reset();
    bus.read_data = 32'h3;
    set_req(0, OP_RS, 12'h300, 32'h8);
    step();
    clear_reqs();
    step();
    @(negedge clk);
    total++;
    if (bus.write_enable !== 1'b1 || bus.write_data !== 32'hB) begin
      bad++;
      $display("FAIL rst_mid_inwrite: got we=%b wd=%h, want 1 b", bus.write_enable, bus.write_data);
    end
    reset = 1'b1;
    step();
    set_req(0, OP_READ, 12'hC00, 32'h0);
    set_req(1, OP_READ, 12'hC01, 32'h0);
    @(negedge clk);
    total++;
    if (bus.write_enable !== 1'b0 || bus.rsp_valid !== 1'b0 || busy !== 1'b0 || bus.req_ready !== 2'b00) begin
      bad++;
      $display("FAIL rst_mid_after: got we=%b rv=%b busy=%b ready=%b, want 0 0 0 00",
               bus.write_enable, bus.rsp_valid, busy, bus.req_ready);
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.req_ready !== 2'b01 || bus.rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid_rrptr: got ready=%b rv=%b, want 01 0", bus.req_ready, bus.rsp_valid);
    end
    step();
    clear_reqs();
    repeat (3) step();
    $display("test_reset_mid_write done");
  endtask

  initial begin
    clear_reqs();
    bus.rsp_ready = 1'b1;
    bus.read_data = '0;
    test_reset();
    test_read();
    test_rmw();
    test_back_to_back();
    test_backpressure();
    test_fpu_holdoff();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/vx_csr_access_sched.md
Name: vx_csr_access_sched

Overview:
- Schedules CSR accesses from multiple requesters onto the single-ported per-core CSR storage block (one read port, one write port).
- Requesters are the pipeline CSR unit and a host/debug port.
- Arbitrates round-robin and sequences each access as read → optional write → response, implementing CSRRW/CSRRS/CSRRC read-modify-write atomically.
- Holds off floating-point CSR accesses while FPU flag updates are still in flight.

Parameters:
- NUM_REQS, 2, number of requesters (≥1)
- ADDR_BITS, 12, CSR address width
- DATA_BITS, 32, CSR data width
- WID_BITS, 2, warp id width
- UUID_BITS, 44, instruction uuid width

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- req_valid  in  NUM_REQS  per-requester request valid
- req_op  in  NUM_REQS*2  per requester: 0=READ, 1=RW, 2=RS, 3=RC
- req_addr  in  NUM_REQS*ADDR_BITS  CSR address
- req_wid  in  NUM_REQS*WID_BITS  warp id
- req_uuid  in  NUM_REQS*UUID_BITS  uuid
- req_data  in  NUM_REQS*DATA_BITS  write value / mask
- req_ready  out  NUM_REQS  per-requester accept
- rsp_valid  out  1  response valid
- rsp_idx  out  max(1,$clog2(NUM_REQS))  requester index the response belongs to
- rsp_data  out  DATA_BITS  CSR value before modification
- rsp_uuid  out  UUID_BITS  uuid of the access
- rsp_ready  in  1  response accept
- fpu_pending  in  1  FPU fflags updates outstanding
- read_enable  out  1  CSR storage read strobe
- read_addr  out  ADDR_BITS  read address
- read_wid  out  WID_BITS  read warp id
- read_uuid  out  UUID_BITS  read uuid
- read_data  in  DATA_BITS  combinational read result
- write_enable  out  1  CSR storage write strobe
- write_addr  out  ADDR_BITS  write address
- write_wid  out  WID_BITS  write warp id
- write_uuid  out  UUID_BITS  write uuid
- write_data  out  DATA_BITS  write value
- busy  out  1  access in progress (state != IDLE)

Behaviour:
- FSM states: IDLE, READ, WRITE, RSP. All state is registered; reset forces IDLE, rr_ptr=0, and all captured registers to 0.
- Eligibility: requester i is eligible iff req_valid[i] and NOT (fpu_pending and req_addr[i] in 0x001..0x003).
- IDLE:
  - Grant the first eligible requester scanning from rr_ptr upward, with wrap-around.
  - req_ready[g]=1 combinationally in that cycle only; all other req_ready=0.
  - req_ready is 0 in every non-IDLE state.
  - On grant: capture op/addr/wid/uuid/data/idx, set rr_ptr=(g+1) mod NUM_REQS, go to READ. No eligible requester → stay in IDLE.
- READ (1 cycle):
  - read_enable=1; read_* driven from captured registers.
  - Sample read_data into old_r.
  - Compute new_r: RW → data; RS → old|data; RC → old&~data.
  - Write is needed iff op==RW, or op∈{RS,RC} with data≠0. If needed go to WRITE, else go to RSP.
- WRITE (1 cycle): write_enable=1, write_data=new_r, write_addr/wid/uuid from captured registers; then go to RSP.
- RSP:
  - rsp_valid=1, rsp_data=old_r, rsp_idx and rsp_uuid from captured registers.
  - Hold all of these stable until rsp_ready; on rsp_valid&rsp_ready go to IDLE.
- Latency, grant cycle = T:
  - read at T+1
  - write at T+2 (if needed)
  - rsp_valid from T+3 with a write, T+2 without
  - earliest next grant = cycle after the response handshake
- Strobe outputs: read_enable and write_enable are never asserted together and are never asserted in IDLE or RSP. Both are 0 during and immediately after reset.
- Output reset values: rsp_valid=0, busy=0, req_ready=0 while reset is high. rsp_data, rsp_idx and rsp_uuid are 0.
- Reset mid-operation: the access is dropped; no write is issued, no response is produced, and the requester must re-issue.
- fpu_pending rising after grant does not affect the access in flight; blocking applies only at arbitration.
- Request fields are only sampled in the grant cycle; requesters may change them afterwards.

Test Plan:
- Single READ: req0 READ addr 0xC00, read_data=0x1234 → read_enable at T+1, no write_enable, rsp_valid at T+2 with rsp_data=0x1234, rsp_idx=0.
- RS: req0 RS addr 0x300 data=0x8, read_data=0x3 → write_enable at T+2 with write_data=0xB; rsp_data=0x3 at T+3. Repeat with data=0 → no write, rsp at T+2.
- RC and RW: RC data=0x1, old 0x3 → write_data 0x2. RW data=0xAA, old 0x55 → write_data 0xAA, rsp_data 0x55.
- Round-robin: req0 and req1 both continuously valid → grants alternate 0,1,0,1. rsp_ready held low 5 cycles → response stable and no new grant.
- FP hold-off: fpu_pending=1, req0 addr 0x003, req1 addr 0x300 → req1 granted, req0 waits; fpu_pending=0 → req0 granted next IDLE.
- Reset during WRITE state → write_enable=0 in the cycle following reset, no rsp_valid, busy=0, next grant starts from requester 0.
